// File: rtl/rv32_pkg.sv
// rv32_pkg: shared widths, fetch increment and fetch state encoding for the RV32I front end
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam int IMM_FIELD_W = 25;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} fetch_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two depth FIFO with flush; push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int W = 32,
  parameter int D = 2,
  localparam int AW = $clog2(D),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  // next pointers and occupancy; flush wins over any push or pop
  always_comb begin
    do_pop = pop && count_q != '0;
    do_push = push && (count_q != CW'(D) || do_pop);
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  // pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset; it is only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage; optional misaligned-redirect trap under FETCH_MISALIGN_CHECK_EN
module inst_fetch
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_W-1:0]     imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_W-1:0]     dec_instr,
  output logic [XLEN-1:0]        dec_pc,
  output logic [IMM_FIELD_W-1:0] dec_imm_field
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                   fetch_misalign
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, tgt, shadow_pc;
  logic [CW-1:0] drop_q, drop_d, out_cnt, buf_cnt;
  logic [XLEN+INSTR_W-1:0] head;
  logic req_hs, rsp_live, rsp_any, dec_hs, mis;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign fetch_misalign = misalign_q;
`endif
  // request gating, drop bookkeeping and next state; a pop this cycle frees a slot so L=1 streams at full rate
  always_comb begin
    tgt = redirect_pc & ~32'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis = redirect_valid && redirect_pc[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    dec_valid = buf_cnt != '0;
    dec_hs = dec_valid && dec_ready;
    imem_req_valid = state_q == FETCH && !redirect_valid && (out_cnt + buf_cnt - CW'(dec_hs) < CW'(FIFO_DEPTH));
    imem_req_addr = pc_q;
    req_hs = imem_req_valid && imem_req_ready;
    rsp_any = imem_rsp_valid && (drop_q != '0 || out_cnt != '0);
    rsp_live = imem_rsp_valid && drop_q == '0 && out_cnt != '0;
    pc_d = redirect_valid ? tgt : req_hs ? pc_q + PC_INC : pc_q;
    drop_d = redirect_valid ? drop_q + out_cnt + CW'(req_hs) - CW'(rsp_any)
                            : drop_q - CW'(imem_rsp_valid && drop_q != '0);
    state_d = redirect_valid ? (mis ? HALT : drop_d != '0 ? FLUSH : FETCH)
            : state_q == IDLE ? FETCH
            : (state_q == FLUSH && drop_d == '0) ? FETCH : state_q;
    dec_instr = dec_valid ? head[INSTR_W-1:0] : '0;
    dec_pc = dec_valid ? head[XLEN+INSTR_W-1:INSTR_W] : '0;
    dec_imm_field = dec_instr[31:7];
  end
  // fetch state machine with PC, drop counter and misalign pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      drop_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= mis;
`endif
    end
  end
  sync_fifo #(.W(XLEN+INSTR_W), .D(FIFO_DEPTH)) u_buf (
    .clk(clk), .rst(rst), .push(rsp_live && !redirect_valid), .din({shadow_pc, imem_rsp_data}),
    .pop(dec_hs), .flush(redirect_valid), .dout(head), .count(buf_cnt)
  );
  sync_fifo #(.W(XLEN), .D(FIFO_DEPTH)) u_shadow (
    .clk(clk), .rst(rst), .push(req_hs), .din(pc_q),
    .pop(rsp_live), .flush(redirect_valid), .dout(shadow_pc), .count(out_cnt)
  );
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (drop_q != '0 || out_cnt != '0));
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: bench for inst_fetch; FETCH_MISALIGN_CHECK_EN selects the misalign checks
module tb_inst_fetch;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, dec_valid, dec_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, dec_instr, dec_pc;
  logic [24:0] dec_imm_field;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_misalign;
`endif
  inst_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_imm_field(dec_imm_field)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );
  typedef struct {logic [31:0] instr; logic [24:0] imm;} vec_t;
  typedef struct {logic [31:0] addr; int due;} pend_t;
  vec_t vecs [6];
  pend_t pq [$];
  int checks = 0, errors = 0;
  int cyc, lat, rdy_pct, dec_pct, nreq, ndec, in_flight;
  bit use_tbl, redir_prev, s_req_valid, s_dec_valid, s_mis;
  logic [31:0] exp_dec_pc, exp_req_pc, last_dec_pc, last_req_addr;
  logic [31:0] got_instr [16];
  logic [24:0] got_imm [16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (use_tbl && a < 32'd24) return vecs[a[4:2]].instr;
    return a;
  endfunction
  task automatic drive();
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(pq[0].addr);
      void'(pq.pop_front());
    end
    imem_req_ready = int'($urandom_range(99)) < rdy_pct;
    dec_ready = int'($urandom_range(99)) < dec_pct;
  endtask
  task automatic tick();
    logic [31:0] w;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_dec_valid = dec_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    s_mis = fetch_misalign;
`else
    s_mis = 1'b0;
`endif
    if (redir_prev) chk("dec_valid_after_redirect", 32'(dec_valid), 0);
    if (redirect_valid) chk("req_valid_during_redirect", 32'(imem_req_valid), 0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req_pc);
      pq.push_back('{imem_req_addr, cyc + lat});
      last_req_addr = imem_req_addr;
      exp_req_pc += 32'd4;
      nreq++;
      in_flight++;
    end
    if (imem_rsp_valid) in_flight--;
    chk("in_flight_cap", 32'(in_flight <= DEPTH), 1);
    if (dec_valid && dec_ready) begin
      w = mem_word(exp_dec_pc);
      chk("dec_pc", dec_pc, exp_dec_pc);
      chk("dec_instr", dec_instr, w);
      chk("dec_imm_field", 32'(dec_imm_field), {7'd0, w[31:7]});
      if (ndec < 16) begin
        got_instr[ndec] = dec_instr;
        got_imm[ndec] = dec_imm_field;
      end
      last_dec_pc = dec_pc;
      exp_dec_pc += 32'd4;
      ndec++;
    end
    if (redirect_valid) begin
      exp_dec_pc = redirect_pc & ~32'd3;
      exp_req_pc = exp_dec_pc;
    end
    redir_prev = redirect_valid;
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask
  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    pq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fetch_misalign", 32'(fetch_misalign), 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; nreq = 0; ndec = 0; in_flight = 0; redir_prev = 1'b0;
    exp_dec_pc = '0; exp_req_pc = '0;
    drive();
  endtask
  task automatic wait_dec(input string name, input logic [31:0] exp_pc);
    int n0;
    bit got;
    n0 = ndec;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = ndec > n0;
    end
    chk({name, "_arrived"}, 32'(got), 1);
    if (got) chk(name, last_dec_pc, exp_pc);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int first, n0;
    vecs[0] = '{32'hFE010113, 25'h1FC0202};
    vecs[1] = '{32'h00000013, 25'h0000000};
    vecs[2] = '{32'hFFFFFFFF, 25'h1FFFFFF};
    vecs[3] = '{32'h80000000, 25'h1000000};
    vecs[4] = '{32'h12345678, 25'h02468AC};
    vecs[5] = '{32'h00000080, 25'h0000001};
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    use_tbl = 1'b0; lat = 1; rdy_pct = 100; dec_pct = 100; cyc = 0;
    // first-instruction latency and back-to-back delivery at L=1
    do_reset();
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) chk("idle_no_request", 32'(s_req_valid), 0);
      if (i == 1) chk("first_request", 32'(s_req_valid), 1);
      if (s_dec_valid && first < 0) first = i;
    end
    chk("first_dec_latency", 32'(first), 3);
    chk("streaming_count", 32'(ndec), 7);
    // decode stalled: only FIFO_DEPTH requests go out
    dec_pct = 0;
    do_reset();
    repeat (12) tick();
    chk("stalled_req_count", 32'(nreq), DEPTH);
    chk("stalled_req_valid_low", 32'(s_req_valid), 0);
    dec_pct = 100;
    n0 = ndec;
    repeat (20) tick();
    chk("release_throughput", 32'(ndec - n0 >= 15), 1);
    // immediate field table
    use_tbl = 1'b1;
    do_reset();
    repeat (14) tick();
    chk("tbl_count", 32'(ndec >= 6), 1);
    for (int i = 0; i < 6; i++) begin
      chk("tbl_instr", got_instr[i], vecs[i].instr);
      chk("tbl_imm", 32'(got_imm[i]), 32'(vecs[i].imm));
    end
    use_tbl = 1'b0;
    // redirect with two requests in flight at L=3
    lat = 3;
    do_reset();
    for (int i = 0; i < 10 && nreq < 2; i++) tick();
    chk("two_in_flight", 32'(nreq), 2);
    redirect(32'h100);
    wait_dec("redirect_l3", 32'h100);
    // redirect while a response arrives during streaming at L=1
    lat = 1;
    do_reset();
    repeat (6) tick();
    redirect(32'h40);
    wait_dec("redirect_with_rsp", 32'h40);
    redirect(32'h80);
    redirect(32'hC0);
    wait_dec("back_to_back_redirect", 32'hC0);
    // PC wrap past the top of the address space
    redirect(32'hFFFF_FFF8);
    n0 = ndec;
    repeat (10) tick();
    chk("wrap_progress", 32'(ndec - n0 >= 4), 1);
    // misaligned redirect
    lat = 2;
    do_reset();
    repeat (6) tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect(32'h102);
    chk("misalign_before_pulse", 32'(s_mis), 0);
    tick();
    chk("misalign_pulse", 32'(s_mis), 1);
    tick();
    chk("misalign_pulse_end", 32'(s_mis), 0);
    n0 = nreq;
    repeat (8) tick();
    chk("halt_no_requests", 32'(nreq - n0), 0);
    chk("halt_no_decode", 32'(s_dec_valid), 0);
    redirect(32'h200);
    wait_dec("resume_after_halt", 32'h200);
`else
    redirect(32'h102);
    wait_dec("misaligned_forced", 32'h100);
    chk("misaligned_req_addr", 32'(last_req_addr[1:0]), 0);
`endif
    // randomized traffic against the reference stream model
    for (int s = 0; s < 4; s++) begin
      lat = int'($urandom_range(4, 1));
      rdy_pct = 70;
      dec_pct = 60;
      do_reset();
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(99) < 4) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          redirect($urandom & 32'hFFFF_FFFC);
`else
          redirect($urandom);
`endif
        end else tick();
      end
      chk("random_progress", 32'(ndec > 50), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
